mem_stage: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the ALU result, store data and memory/write-back controls.
- Performs loads/stores against an external data memory over a req/ack handshake with a timeout, stalling the pipeline while an access is outstanding.
- Presents a registered MEM/WB result (write-back data, destination register, write enable) to the write-back stage.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_REG_ADDR_WIDTH = 4;

   // Access FSM: IDLE accepts a new instruction, WAIT holds one outstanding access.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Reasons the stage can raise its error pulse.
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_TIMEOUT  = 2'd1,
      ERR_MISALIGN = 2'd2,
      ERR_ILLEGAL  = 2'd3
   } err_cause_t;

   // Word accesses only: any set low address bit is a misalignment.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack handshake with a
// timeout, stalls upstream while busy, and registers the MEM/WB result.
// All state moves on the falling clock edge, like the other stage registers.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int TIMEOUT        = 15
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      valid_in,
   input  logic [DATA_WIDTH-1:0]     ALUResult_in,
   input  logic [DATA_WIDTH-1:0]     storeData_in,
   input  logic                      memRead_in,
   input  logic                      memWrite_in,
   input  logic                      memToReg_in,
   input  logic [REG_ADDR_WIDTH-1:0] registerFileWrite_in,
   output logic [DATA_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   output logic                      dmem_read,
   output logic                      dmem_write,
   input  logic                      dmem_ack,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   output logic                      stall,
   output logic                      error,
   output logic [DATA_WIDTH-1:0]     writeBackData,
   output logic [REG_ADDR_WIDTH-1:0] registerFileWrite,
   output logic                      regWrite
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mem_state_t                state, state_n;
   logic [CW-1:0]             cnt, cnt_n;
   logic                      m2r_q, m2r_n;
   logic [REG_ADDR_WIDTH-1:0] dest_q, dest_n;
   logic [DATA_WIDTH-1:0]     addr_n, wdata_n, wb_n;
   logic [REG_ADDR_WIDTH-1:0] rf_n;
   logic                      rd_n, wr_n, stall_n, error_n, regwrite_n;

   logic mem_op;
   assign mem_op = memRead_in | memWrite_in;

   // Next-state and next-output decode; error/regWrite default low so they pulse.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      m2r_n      = m2r_q;
      dest_n     = dest_q;
      addr_n     = dmem_addr;
      wdata_n    = dmem_wdata;
      rd_n       = dmem_read;
      wr_n       = dmem_write;
      stall_n    = stall;
      wb_n       = writeBackData;
      rf_n       = registerFileWrite;
      error_n    = 1'b0;
      regwrite_n = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in) begin
               if (memRead_in && memWrite_in) begin
                  error_n = 1'b1;
               end else if (mem_op && is_misaligned(ALUResult_in[1:0])) begin
                  error_n = 1'b1;
               end else if (mem_op) begin
                  addr_n  = ALUResult_in;
                  wdata_n = storeData_in;
                  rd_n    = memRead_in;
                  wr_n    = memWrite_in;
                  m2r_n   = memToReg_in;
                  dest_n  = registerFileWrite_in;
                  stall_n = 1'b1;
                  cnt_n   = '0;
                  state_n = WAIT;
               end else begin
                  wb_n       = ALUResult_in;
                  rf_n       = registerFileWrite_in;
                  regwrite_n = 1'b1;
               end
            end
         end
         WAIT: begin
            // Ack is checked first so an ack on the final edge beats the timeout.
            if (dmem_ack) begin
               if (dmem_read) begin
                  wb_n       = m2r_q ? dmem_rdata : dmem_addr;
                  rf_n       = dest_q;
                  regwrite_n = 1'b1;
               end
               rd_n    = 1'b0;
               wr_n    = 1'b0;
               stall_n = 1'b0;
               state_n = IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               error_n = 1'b1;
               rd_n    = 1'b0;
               wr_n    = 1'b0;
               stall_n = 1'b0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers, falling edge, async active-low clear.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         cnt               <= '0;
         m2r_q             <= 1'b0;
         dest_q            <= '0;
         dmem_addr         <= '0;
         dmem_wdata        <= '0;
         dmem_read         <= 1'b0;
         dmem_write        <= 1'b0;
         stall             <= 1'b0;
         error             <= 1'b0;
         writeBackData     <= '0;
         registerFileWrite <= '0;
         regWrite          <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         m2r_q             <= m2r_n;
         dest_q            <= dest_n;
         dmem_addr         <= addr_n;
         dmem_wdata        <= wdata_n;
         dmem_read         <= rd_n;
         dmem_write        <= wr_n;
         stall             <= stall_n;
         error             <= error_n;
         writeBackData     <= wb_n;
         registerFileWrite <= rf_n;
         regWrite          <= regwrite_n;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes expected events, the
// monitor pops and compares them whenever the stage shows a request,
// a write-back or an error pulse.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] ALUResult_in = '0;
   logic [31:0] storeData_in = '0;
   logic        memRead_in = 1'b0;
   logic        memWrite_in = 1'b0;
   logic        memToReg_in = 1'b0;
   logic [3:0]  registerFileWrite_in = '0;
   logic [31:0] dmem_addr, dmem_wdata, writeBackData;
   logic        dmem_read, dmem_write, stall, error, regWrite;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [3:0]  registerFileWrite;

   mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
      .ALUResult_in(ALUResult_in), .storeData_in(storeData_in),
      .memRead_in(memRead_in), .memWrite_in(memWrite_in), .memToReg_in(memToReg_in),
      .registerFileWrite_in(registerFileWrite_in),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .error(error), .writeBackData(writeBackData),
      .registerFileWrite(registerFileWrite), .regWrite(regWrite)
   );

   always #5 clock = ~clock;

   // Expected events: 0 = request issued, 1 = write-back, 2 = error pulse.
   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  d;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
      exp_t e;
      e.kind = kind; e.a = a; e.b = b; e.d = d;
      q.push_back(e);
   endtask

   // Monitor: outputs settle on the falling edge, so sample on the rising edge.
   initial begin
      logic prev_strobe;
      logic strobe;
      exp_t e;
      prev_strobe = 1'b0;
      forever begin
         @(posedge clock);
         strobe = dmem_read | dmem_write;
         chk("stall_tracks_strobe", {31'd0, stall}, {31'd0, strobe});
         if (strobe && !prev_strobe) begin
            if (q.size() == 0) chk("unexpected_request", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("req_kind", 32'(e.kind), 32'd0);
               chk("req_read", {31'd0, dmem_read}, {31'd0, e.d[0]});
               chk("req_write", {31'd0, dmem_write}, {31'd0, ~e.d[0]});
               chk("req_addr", dmem_addr, e.a);
               if (!e.d[0]) chk("req_wdata", dmem_wdata, e.b);
            end
         end
         if (regWrite) begin
            if (q.size() == 0) chk("unexpected_writeback", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("wb_kind", 32'(e.kind), 32'd1);
               chk("wb_data", writeBackData, e.a);
               chk("wb_dest", {28'd0, registerFileWrite}, {28'd0, e.d});
            end
         end
         if (error) begin
            if (q.size() == 0) chk("unexpected_error", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("err_kind", 32'(e.kind), 32'd2);
            end
         end
         prev_strobe = strobe;
      end
   end

   // One instruction; for memory ops the bench also plays the memory,
   // raising ack on the j-th edge spent waiting (j > TO means never).
   task automatic run_instr(input logic rd, input logic wr, input logic m2r,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic [3:0] dest, input int j, input logic [31:0] rdata);
      logic memop, bad;
      int   m;
      memop = rd | wr;
      bad   = (rd && wr) || (memop && alu[1:0] != 2'b00);
      @(posedge clock);
      valid_in = 1'b1; ALUResult_in = alu; storeData_in = sd;
      memRead_in = rd; memWrite_in = wr; memToReg_in = m2r; registerFileWrite_in = dest;
      dmem_ack = 1'($urandom_range(0, 1));
      if (!memop) push(1, alu, 0, dest);
      else if (bad) push(2, 0, 0, 0);
      else begin
         push(0, alu, sd, {3'd0, rd});
         if (j > TO) push(2, 0, 0, 0);
         else if (rd) push(1, m2r ? rdata : alu, 0, dest);
      end
      @(posedge clock);
      if (memop && !bad) begin
         m = (j < TO) ? j : TO;
         for (int i = 1; i <= m; i++) begin
            chk("stall_in_wait", {31'd0, stall}, 32'd1);
            dmem_ack = (i == j);
            dmem_rdata = (i == j) ? rdata : 32'($urandom);
            @(posedge clock);
         end
         chk("stall_after", {31'd0, stall}, 32'd0);
         chk("strobes_after", {30'd0, dmem_read, dmem_write}, 32'd0);
      end else begin
         chk("no_strobe", {30'd0, dmem_read, dmem_write}, 32'd0);
      end
      dmem_ack = 1'b0;
      valid_in = 1'b0;
   endtask

   initial begin
      int kind, gap;
      logic [31:0] a;
      // Reset state
      #12;
      chk("rst_outputs", {dmem_read, dmem_write, stall, error, regWrite}, 0);
      chk("rst_wb", writeBackData, 0);
      chk("rst_addr", dmem_addr | dmem_wdata, 0);
      chk("rst_dest", {28'd0, registerFileWrite}, 0);
      reset_n = 1'b1;

      // Directed cases
      run_instr(0, 0, 0, 32'h0000_002A, 0, 4'd5, 0, 0);
      run_instr(1, 0, 1, 32'h0000_0100, 0, 4'd7, 3, 32'hDEAD_BEEF);
      run_instr(0, 1, 0, 32'h0000_0204, 32'h1234_5678, 4'd2, 1, 0);
      run_instr(1, 0, 1, 32'h0000_0300, 0, 4'd3, TO + 1, 32'h5555_AAAA);
      run_instr(1, 0, 1, 32'h0000_0304, 0, 4'd4, TO, 32'hCAFE_F00D);
      run_instr(1, 0, 0, 32'h0000_0308, 0, 4'd6, 2, 32'h1111_2222);
      run_instr(1, 0, 1, 32'h0000_0102, 0, 4'd1, 1, 0);
      run_instr(1, 1, 1, 32'h0000_0400, 0, 4'd1, 1, 0);

      // Randomized mix, with random idle gaps where stray acks must be ignored
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 3);
         a = $urandom;
         if (kind != 0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                   a, $urandom, 4'($urandom), $urandom_range(1, TO + 2), $urandom);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clock);
            dmem_ack = 1'($urandom_range(0, 1));
         end
         dmem_ack = 1'b0;
      end

      // Reset in the middle of an outstanding load
      @(posedge clock);
      valid_in = 1'b1; ALUResult_in = 32'h0000_0500; memRead_in = 1'b1;
      memWrite_in = 1'b0; memToReg_in = 1'b1; registerFileWrite_in = 4'd9;
      push(0, 32'h0000_0500, 0, 4'd1);
      @(posedge clock);
      chk("pre_rst_stall", {31'd0, stall}, 32'd1);
      valid_in = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_read", {31'd0, dmem_read}, 0);
      chk("midrst_stall", {31'd0, stall}, 0);
      chk("midrst_regwrite", {31'd0, regWrite}, 0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      run_instr(0, 0, 0, 32'h0000_0077, 0, 4'd11, 0, 0);

      repeat (3) @(posedge clock);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
